uart_tx_buf: RTL

Buffered UART transmitter: accepts bytes on a single-cycle strobe into an internal FIFO and serialises them on `tx` as 8N1 frames, back-to-back while data remains. It is the transmit-side companion to the UART receive path and sits between any byte producer (receiver loopback, command logic) and the board TX pin. Producers can burst up to `DEPTH` bytes without waiting on the line rate.

---
 rtl/uart_tx_buf.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered 8N1 UART transmitter.
// Bytes strobed in on pi_flag are queued and sent back-to-back on tx.
// Ports:
//   sys_clk, sys_rst   clock, async active-high reset
//   pi_data, pi_flag   byte in, one-cycle write strobe
//   tx                 serial line, idle high, registered
//   po_full            FIFO holds DEPTH bytes
//   po_busy            frame in progress
//   po_done            pulse on last clock of each stop bit
//   po_overflow        sticky, a write was dropped
module uart_tx_buf #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEPTH    = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       po_full,
  output logic       po_busy,
  output logic       po_done,
  output logic       po_overflow
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BW =
    (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int AW = $clog2(DEPTH);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(BAUD_CNT_MAX - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_q, tx_nxt;
  logic          ovf_q;
  logic          push, pop, bit_end, has_data;

  assign bit_end  = (baud == BAUD_LAST);
  assign has_data = (cnt != '0);
  assign po_full  = (cnt == FULL_CNT);
  // A write while full is dropped even if a pop
  // frees a slot in the same cycle.
  assign push     = pi_flag & ~po_full;

  assign tx          = tx_q;
  assign po_busy     = (state != IDLE);
  assign po_done     = (state == STOP) & bit_end;
  assign po_overflow = ovf_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shift_nxt = shift;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_data) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (has_data) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter parks at zero in IDLE, so entering START
  // always begins a full bit period.
  always_comb begin
    baud_nxt = '0;
    if (state != IDLE && !bit_end) begin
      baud_nxt = baud + BAUD_ONE;
    end
  end

  // tx is registered from next-state values so the
  // line changes on the same edge as the state.
  always_comb begin
    tx_nxt = 1'b1;
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[idx_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      baud  <= baud_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx_q  <= tx_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop && !push) begin
        cnt <= cnt - CNT_ONE;
      end
      if (pi_flag && po_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule
